// File: rtl/mac_sequencer.sv
// Sequences one dot product of N_TERMS pairs into a DSP48A1 MAC, then scales/saturates data_p into result.
// Result valid 4+N_TERMS*(3+ISSUE_GAP)+MAC_LATENCY+1 cycles after start; held until result_ready. Define MAC_SEQUENCER_RELU_EN to clamp negatives to 0.
module mac_sequencer #(
    parameter int N_TERMS     = 784,
    parameter int X_ADDR_W    = 10,
    parameter int W_ADDR_W    = 14,
    parameter int OUT_W       = 18,
    parameter int FRAC_SHIFT  = 8,
    parameter int ISSUE_GAP   = 2,
    parameter int MAC_LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [W_ADDR_W-1:0]        w_base,
    output logic                       busy,
    output logic                       x_rd_en,
    output logic [X_ADDR_W-1:0]        x_addr,
    input  logic [17:0]                x_data,
    output logic                       w_rd_en,
    output logic [W_ADDR_W-1:0]        w_addr,
    input  logic [17:0]                w_data,
    output logic                       mac_reset,
    output logic [17:0]                data_a,
    output logic [17:0]                data_b,
    output logic                       mac_start_operation,
    input  logic [47:0]                data_p,
    output logic signed [OUT_W-1:0]    result,
    output logic                       result_valid,
    input  logic                       result_ready
);

    if (N_TERMS < 1) begin : g_chk_terms
        $error("mac_sequencer: N_TERMS must be >= 1");
    end
    if (ISSUE_GAP < 1) begin : g_chk_gap
        $error("mac_sequencer: ISSUE_GAP must be >= 1");
    end
    if (OUT_W > 48 - FRAC_SHIFT) begin : g_chk_outw
        $error("mac_sequencer: OUT_W must be <= 48 - FRAC_SHIFT");
    end

    localparam int K_W      = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int CNT_MAX0 = (ISSUE_GAP > 3) ? ISSUE_GAP : 3;
    localparam int CNT_MAX  = (MAC_LATENCY > CNT_MAX0) ? MAC_LATENCY : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX);

    localparam logic [K_W-1:0]   K_LAST     = K_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(2);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(ISSUE_GAP - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);

    localparam logic signed [47:0] SAT_MAX = {{(48 - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [47:0] SAT_MIN = {{(48 - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_LOAD,
        S_FIRE,
        S_HOLD,
        S_DRAIN,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [K_W-1:0]           r_k;
    logic [K_W-1:0]           w_k_nxt;
    logic [W_ADDR_W-1:0]      r_w_base;
    logic [17:0]              r_data_a;
    logic [17:0]              r_data_b;
    logic signed [OUT_W-1:0]  r_result;
    logic                     w_latch_base;
    logic                     w_load_ops;
    logic                     w_capture;

    logic signed [47:0]       w_shifted;
    logic signed [OUT_W-1:0]  w_sat;
    logic signed [OUT_W-1:0]  w_final;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_k      <= '0;
            r_w_base <= '0;
            r_data_a <= '0;
            r_data_b <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
            if (w_latch_base) begin
                r_w_base <= w_base;
            end
            if (w_load_ops) begin
                r_data_a <= x_data;
                r_data_b <= w_data;
            end
            if (w_capture) begin
                r_result <= w_final;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_k_nxt      = r_k;
        w_latch_base = 1'b0;
        w_load_ops   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch_base = 1'b1;
                    w_k_nxt      = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_cnt == CLR_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_load_ops  = 1'b1;
                w_state_nxt = S_FIRE;
            end
            S_FIRE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_k == K_LAST) begin
                        w_state_nxt = (MAC_LATENCY > 0) ? S_DRAIN : S_CAPTURE;
                    end else begin
                        w_k_nxt     = r_k + K_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (result_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Scale, then clamp into the signed OUT_W range before truncating.
    assign w_shifted = $signed(data_p) >>> FRAC_SHIFT;

    always_comb begin
        w_sat = w_shifted[OUT_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = OUT_MAX;
        end else if (w_shifted < SAT_MIN) begin
            w_sat = OUT_MIN;
        end
`ifdef MAC_SEQUENCER_RELU_EN
        w_final = w_sat[OUT_W-1] ? '0 : w_sat;
`else
        w_final = w_sat;
`endif
    end

    // MAC stays cleared while idle/reset; the last CLEAR cycle releases it so OPMODE can reload.
    assign mac_reset           = (r_state == S_IDLE) || ((r_state == S_CLEAR) && (r_cnt != CLR_LAST));
    assign busy                = (r_state != S_IDLE);
    assign x_rd_en             = (r_state == S_FETCH);
    assign w_rd_en             = (r_state == S_FETCH);
    assign x_addr              = X_ADDR_W'(r_k);
    assign w_addr              = r_w_base + W_ADDR_W'(r_k);
    assign data_a              = r_data_a;
    assign data_b              = r_data_b;
    assign mac_start_operation = (r_state == S_FIRE);
    assign result              = r_result;
    assign result_valid        = (r_state == S_OUT);

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with N_TERMS=4: table of dot-product vectors plus stall, back-to-back and reset-abort sequences.
module tb_mac_sequencer;

    localparam int NV = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [13:0]        w_base;
    logic               busy;
    logic               x_rd_en;
    logic [9:0]         x_addr;
    logic [17:0]        x_data = '0;
    logic               w_rd_en;
    logic [13:0]        w_addr;
    logic [17:0]        w_data = '0;
    logic               mac_reset;
    logic [17:0]        data_a;
    logic [17:0]        data_b;
    logic               mac_start_operation;
    logic [47:0]        data_p;
    logic signed [17:0] result;
    logic               result_valid;
    logic               result_ready;

    mac_sequencer #(.N_TERMS(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .w_base(w_base), .busy(busy),
        .x_rd_en(x_rd_en), .x_addr(x_addr), .x_data(x_data),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .mac_reset(mac_reset), .data_a(data_a), .data_b(data_b),
        .mac_start_operation(mac_start_operation), .data_p(data_p),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][17:0] x;
        logic [3:0][17:0] w;
        logic [13:0]      base;
        int               exp;
    } vec_t;

    vec_t vecs [NV];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Memories with one-cycle synchronous read
    logic [17:0] x_mem [1024];
    logic [17:0] w_mem [16384];
    always @(posedge clk) begin
        if (x_rd_en) x_data <= x_mem[x_addr];
        if (w_rd_en) w_data <= w_mem[w_addr];
    end

    // Behavioural MAC: clear on mac_reset, accumulate on fire, two-stage output pipe
    logic signed [47:0] acc = '0;
    logic signed [47:0] p_d1 = '0;
    logic signed [47:0] p_d2 = '0;
    logic signed [47:0] a_ext;
    logic signed [47:0] b_ext;
    assign a_ext  = {{30{data_a[17]}}, data_a};
    assign b_ext  = {{30{data_b[17]}}, data_b};
    assign data_p = p_d2;
    always @(posedge clk) begin
        if (mac_reset) acc <= '0;
        else if (mac_start_operation) acc <= acc + a_ext * b_ext;
        p_d1 <= acc;
        p_d2 <= p_d1;
    end

    // Scoreboard and bus monitors
    int          sb_q [$];
    int          fire_cnt = 0;
    logic [13:0] wa_q [$];
    logic [9:0]  xa_q [$];
    logic [13:0] cur_base;
    logic [17:0] hold_a;
    logic [17:0] hold_b;
    int          hold_n = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            hold_n = 0;
        end else begin
            if (hold_n > 0) begin
                chk("operand_a_stable", data_a, hold_a);
                chk("operand_b_stable", data_b, hold_b);
                hold_n--;
            end
            if (mac_start_operation) begin
                fire_cnt++;
                hold_a = data_a;
                hold_b = data_b;
                hold_n = 2;
            end
            if (w_rd_en) begin
                wa_q.push_back(w_addr);
                xa_q.push_back(x_addr);
            end
        end
    end

    function automatic vec_t mk(input int x0, input int x1, input int x2, input int x3,
                                input int w0, input int w1, input int w2, input int w3,
                                input int base, input int e_lin, input int e_relu);
        vec_t v;
        v.x[0] = 18'(x0); v.x[1] = 18'(x1); v.x[2] = 18'(x2); v.x[3] = 18'(x3);
        v.w[0] = 18'(w0); v.w[1] = 18'(w1); v.w[2] = 18'(w2); v.w[3] = 18'(w3);
        v.base = 14'(base);
`ifdef MAC_SEQUENCER_RELU_EN
        v.exp = e_relu;
`else
        v.exp = e_lin;
`endif
        return v;
    endfunction

    task automatic load_vec(input vec_t v);
        logic [13:0] a;
        for (int k = 0; k < 4; k++) begin
            a = v.base + 14'(k);
            x_mem[k] = v.x[k];
            w_mem[a] = v.w[k];
        end
    endtask

    task automatic arm(input logic [13:0] base, input int exp);
        w_base   = base;
        cur_base = base;
        start    = 1'b1;
        sb_q.push_back(exp);
        fire_cnt = 0;
        wa_q.delete();
        xa_q.delete();
    endtask

    // Returns one cycle after the start edge
    task automatic launch(input vec_t v);
        @(posedge clk); #1;
        arm(v.base, v.exp);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_run();
        int lat = 1;
        int e;
        logic [13:0] ea;
        chk("busy_after_start", busy, 1);
        while (!result_valid && lat < 200) begin
            if (lat <= 3) chk("mac_reset_clear_phase", mac_reset, (lat < 3) ? 1 : 0);
            @(posedge clk); #1;
            lat++;
        end
        if (!result_valid) begin
            chk("result_valid_timeout", 0, 1);
            return;
        end
        chk("result_latency", lat, 28);
        if (sb_q.size() == 0) begin
            chk("scoreboard_underflow", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("result_value", result, e);
        end
        chk("fire_count", fire_cnt, 4);
        chk("fetch_count", wa_q.size(), 4);
        for (int k = 0; k < wa_q.size() && k < 4; k++) begin
            ea = cur_base + 14'(k);
            chk("w_addr_seq", wa_q[k], ea);
            chk("x_addr_seq", xa_q[k], k);
        end
    endtask

    task automatic transfer();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("valid_after_xfer", result_valid, 0);
        chk("busy_after_xfer", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [17:0] r0;
        int n;
        int g;
        int dropped;

        reset_n = 1'b0; start = 1'b0; result_ready = 1'b0; w_base = '0;

        vecs[0] = mk(256, 512, 768, 1024,   256, 256, 256, 256,          100,   2560,   2560);
        vecs[1] = mk(256, 256, 256, 256,    -256, -256, -256, -256,      0,     -1024,  0);
        vecs[2] = mk(131071, 131071, 131071, 131071,
                     131071, 131071, 131071, 131071,                     5000,  131071, 131071);
        vecs[3] = mk(131071, 131071, 131071, 131071,
                     -131072, -131072, -131072, -131072,                 7,     -131072, 0);
        vecs[4] = mk(256, 256, 256, 256,    1024, -512, 256, -256,       16382, 512,    512);
        vecs[5] = mk(1, 0, 0, 0,            -1, 0, 0, 0,                 200,   -1,     0);
        vecs[6] = mk(131071, 1, 0, 0,       256, 256, 0, 0,              300,   131071, 131071);
        vecs[7] = mk(-131072, 0, 0, 0,      256, 0, 0, 0,                400,   -131072, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_x_rd_en", x_rd_en, 0);
        chk("rst_w_rd_en", w_rd_en, 0);
        chk("rst_x_addr", x_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_data_a", data_a, 0);
        chk("rst_data_b", data_b, 0);
        chk("rst_fire", mac_start_operation, 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_mac_reset", mac_reset, 1);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            load_vec(vecs[i]);
            launch(vecs[i]);
            finish_run();
            transfer();
        end

        // Stall in OUT with a stray start pulse
        load_vec(vecs[0]);
        launch(vecs[0]);
        finish_run();
        r0 = result;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            @(posedge clk); #1;
            chk("stall_result", result, r0);
            chk("stall_valid", result_valid, 1);
            chk("stall_busy", busy, 1);
        end
        start = 1'b0;

        // Transfer and start together, then start accepted from IDLE
        load_vec(vecs[2]);
        result_ready = 1'b1;
        arm(vecs[2].base, vecs[2].exp);
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("b2b_valid_dropped", result_valid, 0);
        chk("b2b_idle_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        finish_run();
        transfer();

        // Reset during FIRE of term 2, then a clean rerun
        load_vec(vecs[0]);
        launch(vecs[0]);
        n = 0;
        g = 0;
        while (g < 200) begin
            if (mac_start_operation) begin
                n++;
                if (n == 3) break;
            end
            @(posedge clk); #1;
            g++;
        end
        chk("abort_reached_fire", n, 3);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_fire", mac_start_operation, 0);
        chk("abort_data_a", data_a, 0);
        chk("abort_data_b", data_b, 0);
        chk("abort_x_addr", x_addr, 0);
        chk("abort_w_addr", w_addr, 0);
        chk("abort_x_rd_en", x_rd_en, 0);
        chk("abort_w_rd_en", w_rd_en, 0);
        chk("abort_result", result, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_mac_reset", mac_reset, 1);
            chk("abort_valid", result_valid, 0);
        end
        reset_n = 1'b1;
        if (sb_q.size() > 0) dropped = sb_q.pop_back();
        load_vec(vecs[0]);
        launch(vecs[0]);
        finish_run();
        transfer();

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

- Upstream controller for the DSP48A1 multiply-accumulate stage: computes one neuron dot product per `start`.
- Fetches `N_TERMS` input/weight pairs from two synchronous-read memories, presents them on `data_a`/`data_b`, and fires one `mac_start_operation` per pair.
- Clears the accumulator before the first term, and afterwards captures, rescales, saturates and (optionally) rectifies the 48-bit `data_p`.
- Hands the result downstream on a valid/ready handshake.

## Interface
- `N_TERMS`, 784: terms per dot product; must be ≥1 (elaboration check).
- `X_ADDR_W`, 10: input memory address width.
- `W_ADDR_W`, 14: weight memory address width.
- `OUT_W`, 18: result width, signed; must be ≤ 48-`FRAC_SHIFT`.
- `FRAC_SHIFT`, 8: arithmetic right shift applied to `data_p`.
- `ISSUE_GAP`, 2: hold cycles after each fire; must be ≥1.
- `MAC_LATENCY`, 3: cycles from the last hold to a settled `data_p`.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin an operation; sampled only in IDLE.
- `w_base` in `W_ADDR_W`: weight base address, captured with `start`.
- `busy` out 1: high from the cycle after `start` is accepted until the result transfer.
- `x_rd_en` out 1: input memory read enable.
- `x_addr` out `X_ADDR_W`: input memory address.
- `x_data` in 18: input memory data, valid one cycle after `x_rd_en`.
- `w_rd_en` out 1: weight memory read enable.
- `w_addr` out `W_ADDR_W`: weight memory address.
- `w_data` in 18: weight memory data, valid one cycle after `w_rd_en`.
- `mac_reset` out 1: synchronous clear for the MAC.
- `data_a` out 18: MAC operand A (input sample).
- `data_b` out 18: MAC operand B (weight).
- `mac_start_operation` out 1: one-cycle fire pulse to the MAC.
- `data_p` in 48: MAC accumulator, signed.
- `result` out `OUT_W`: scaled result, signed.
- `result_valid` out 1: result available.
- `result_ready` in 1: downstream accepts the result.

## Operation
**Reset values.** `busy`=0, `x_rd_en`=0, `w_rd_en`=0, addresses 0, `data_a`/`data_b`=0, `mac_start_operation`=0, `result`=0, `result_valid`=0. `mac_reset`=1, so the MAC is held clear while `reset_n` is low.

**FSM.**
- **IDLE:** `start`=1 → latch `w_base`, set k=0 → CLEAR.
- **CLEAR:** 3 cycles. `mac_reset`=1 in cycles 1–2 and 0 in cycle 3, which lets the MAC's registered OPMODE reload → FETCH.
- **FETCH:** `x_rd_en`=`w_rd_en`=1, `x_addr`=k, `w_addr`=`w_base`+k (modulo 2^`W_ADDR_W`) → LOAD.
- **LOAD:** register `x_data`→`data_a` and `w_data`→`data_b` → FIRE.
- **FIRE:** `mac_start_operation`=1 for exactly this cycle → HOLD.
- **HOLD:** `ISSUE_GAP` cycles, operands stable. Then, if k=`N_TERMS`-1 → DRAIN; else k+1 → FETCH.
- **DRAIN:** `MAC_LATENCY` cycles → CAPTURE.
- **CAPTURE:** compute s = `data_p` >>> `FRAC_SHIFT`, clamp s to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1], apply the RELU option, register the value into `result`, set `result_valid`=1 → OUT.
- **OUT:** hold `result`/`result_valid` until `result_ready`=1. On that edge, clear `result_valid` and `busy` → IDLE.

**Rules.**
- `data_a`/`data_b` change only in LOAD; they are stable from FIRE through the end of HOLD.
- `start` is ignored whenever not in IDLE, including OUT.
- `start` and `result_ready` may be high in the same cycle in OUT. The transfer completes; `start` is not accepted until IDLE.
- `reset_n` low in any state aborts immediately to the reset values. No partial result is ever emitted.
- Exactly `N_TERMS` fire pulses per operation.

## Timing
- Throughput: 3+`ISSUE_GAP` cycles per term.
- `start` sampled at edge t. CLEAR occupies t+1..t+3; FETCH of term k begins at t+4+k·(3+`ISSUE_GAP`).
- `result_valid` rises at t+4+`N_TERMS`·(3+`ISSUE_GAP`)+`MAC_LATENCY`+1. With defaults and `N_TERMS`=4: t+28.
- Minimum OUT dwell is 1 cycle (`result_ready` already high). IDLE is re-entered the next cycle, so back-to-back `start` costs one IDLE cycle.

## Configuration
- `MAC_SEQUENCER_RELU_EN` defined: after saturation, negative values become 0, so `result` ∈ [0, 2^(`OUT_W`-1)-1].
- Undefined: the saturated signed value is output unchanged.

## Test plan
- `N_TERMS`=4, x={256,512,768,1024}, w=256 each, `w_base`=100 → `w_addr` 100..103, `data_p`=655360, `result`=2560.
- x=256 ×4, w=-256 ×4 → `data_p`=-262144. `result`=-1024 without RELU; 0 with `MAC_SEQUENCER_RELU_EN`.
- x=w=131071 ×4 → positive overflow, `result`=131071.
- x=131071, w=-131072 ×4 → `result`=-131072 without RELU; 0 with RELU.
- `result_ready` held low 10 cycles with `start` pulsed during OUT → `result`/`result_valid` stable, `busy`=1, `start` ignored. `result_ready`=1 → one transfer, `busy`=0 next cycle, then a new `start` is accepted.
- `reset_n` low during the FIRE of term 2 → all outputs at reset values and `mac_reset`=1 while low. A fresh run of test 1 afterwards → `result`=2560 (no stale accumulation), exactly 4 fire pulses, `result_valid` at t+28.
